// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial/parallel conversion blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sipo_pkg;

  // Order in which word bits travel on the serial line; shared with PISO variants.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  // Bit counter width for a WIDTH-bit word: $clog2(WIDTH), never less than 1,
  // so a one-bit word still gets a (constant-zero) counter register.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: gathers WIDTH accepted bits into one word.
// Latency: word visible on p_out/p_valid right after the edge accepting its last bit.
// Backpressure: one-entry holding register; a word completing while it is full is dropped and sets sticky overflow.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int         CNT_W = cnt_w(int'(WIDTH));
  localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;

  // sync clears the partial word first, so a bit accepted alongside it starts afresh.
  logic [WIDTH-1:0] shift_base;
  logic [CNT_W-1:0] cnt_base;
  logic [WIDTH-1:0] shift_nxt;
  logic             word_done;
  logic             xfer;
  logic             hold_free;

  // Build the post-shift word and the completion/handshake conditions for this edge.
  always_comb begin
    shift_base = sync ? '0 : shift_q;
    cnt_base   = sync ? '0 : cnt_q;
    // Full-width shifts keep WIDTH=1 legal: the new bit simply replaces the word.
    if (ORDER == sipo_pkg::MSB_FIRST) begin
      shift_nxt = (shift_base << 1) | WIDTH'(serial_in);
    end else begin
      shift_nxt = (shift_base >> 1) | (WIDTH'(serial_in) << (WIDTH - 1));
    end
    word_done = serial_valid && (cnt_base == LAST_CNT);
    xfer      = p_valid && p_ready;
    // Holding register can take a new word if empty or being drained on this edge.
    hold_free = !p_valid || p_ready;
  end

  // Shift register: takes accepted bits, is cleared by sync, holds across gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else if (serial_valid) begin
      shift_q <= shift_nxt;
    end else if (sync) begin
      shift_q <= '0;
    end
  end

  // Bit counter: counts accepted bits of the current word and wraps on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (serial_valid) begin
      if (word_done) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_base + CNT_W'(1);
      end
    end else begin
      cnt_q <= cnt_base;
    end
  end

  // Holding register: loads completed words, drains on handshake, flags drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_out    <= '0;
      p_valid  <= 1'b0;
      overflow <= 1'b0;
    end else if (word_done) begin
      if (hold_free) begin
        p_out   <= shift_nxt;
        p_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (xfer) begin
      p_valid <= 1'b0;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (MSB-first, LSB-first and WIDTH=1 instances).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised through p_ready on the main instance and the WIDTH=1 instance.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       serial_valid;
  logic       sync;
  logic       p_ready;
  logic [3:0] p_out;
  logic       p_valid;
  logic       overflow;
  logic       busy;

  logic [3:0] l_p_out;
  logic       l_p_valid;
  logic       l_overflow;
  logic       l_busy;

  logic       w1_in;
  logic       w1_valid;
  logic       w1_sync;
  logic       w1_ready;
  logic [0:0] w1_p_out;
  logic       w1_p_valid;
  logic       w1_overflow;
  logic       w1_busy;

  int checks;
  int errors;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .sync(sync), .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready),
    .overflow(overflow), .busy(busy)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .sync(sync), .p_out(l_p_out), .p_valid(l_p_valid), .p_ready(p_ready),
    .overflow(l_overflow), .busy(l_busy)
  );

  sipo_deserializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .serial_in(w1_in), .serial_valid(w1_valid),
    .sync(w1_sync), .p_out(w1_p_out), .p_valid(w1_p_valid), .p_ready(w1_ready),
    .overflow(w1_overflow), .busy(w1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    tick();
    serial_valid = 1'b0;
    serial_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; sync = 1'b0; p_ready = 1'b1;
    w1_in = 1'b0; w1_valid = 1'b0; w1_sync = 1'b0; w1_ready = 1'b0;
    #2;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_p_out", 32'(p_out), 32'h0);
    check("rst_p_valid", 32'(p_valid), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Test 1: 1,0,1,1 back to back, consumer ready
    send_bit(1'b1); check("t1_busy1", 32'(busy), 32'h1);
    send_bit(1'b0); check("t1_busy2", 32'(busy), 32'h1);
    send_bit(1'b1); check("t1_busy3", 32'(busy), 32'h1); check("t1_nvalid3", 32'(p_valid), 32'h0);
    send_bit(1'b1);
    check("t1_busy4", 32'(busy), 32'h0);
    check("t1_p_out", 32'(p_out), 32'hB);
    check("t1_p_valid", 32'(p_valid), 32'h1);
    check("t1_lsb_p_out", 32'(l_p_out), 32'hD);
    idle(1);
    check("t1_drained", 32'(p_valid), 32'h0);
    check("t1_p_out_kept", 32'(p_out), 32'hB);

    // Test 2: same word with gaps 0, 2, 5
    send_bit(1'b1);
    send_bit(1'b0);
    idle(2);
    check("t2_gap2_valid", 32'(p_valid), 32'h0);
    check("t2_gap2_busy", 32'(busy), 32'h1);
    send_bit(1'b1);
    idle(5);
    check("t2_gap5_valid", 32'(p_valid), 32'h0);
    check("t2_gap5_p_out", 32'(p_out), 32'hB);
    send_bit(1'b1);
    check("t2_p_out", 32'(p_out), 32'hB);
    check("t2_p_valid", 32'(p_valid), 32'h1);
    check("t2_lsb_p_out", 32'(l_p_out), 32'hD);
    check("t2_lsb_p_valid", 32'(l_p_valid), 32'h1);
    idle(1);

    // Test 3: backpressure, second word dropped
    p_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("t3_first_valid", 32'(p_valid), 32'h1);
    check("t3_first_ovf", 32'(overflow), 32'h0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("t3_p_out_held", 32'(p_out), 32'hB);
    check("t3_p_valid", 32'(p_valid), 32'h1);
    check("t3_overflow", 32'(overflow), 32'h1);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("t3_drain_valid", 32'(p_valid), 32'h0);
    check("t3_ovf_sticky", 32'(overflow), 32'h1);
    idle(2);
    check("t3_ovf_sticky2", 32'(overflow), 32'h1);

    // Test 4: completion and drain on the same edge
    do_reset();
    check("t4_rst_ovf", 32'(overflow), 32'h0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("t4_held", 32'(p_out), 32'hB);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    p_ready = 1'b1;
    send_bit(1'b1);
    check("t4_p_out", 32'(p_out), 32'h5);
    check("t4_p_valid", 32'(p_valid), 32'h1);
    check("t4_overflow", 32'(overflow), 32'h0);
    idle(1);
    check("t4_drained", 32'(p_valid), 32'h0);

    // Test 5: sync discards partial "11"
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b0);
    sync = 1'b0;
    check("t5_busy_after_sync", 32'(busy), 32'h1);
    check("t5_no_valid_sync", 32'(p_valid), 32'h0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t5_no_valid_3", 32'(p_valid), 32'h0);
    send_bit(1'b0);
    check("t5_p_out", 32'(p_out), 32'h6);
    check("t5_p_valid", 32'(p_valid), 32'h1);
    idle(1);

    // Test 6: reset mid-word and mid-handshake (with overflow set)
    p_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1);
    check("t6_pre_valid", 32'(p_valid), 32'h1);
    check("t6_pre_ovf", 32'(overflow), 32'h1);
    check("t6_pre_busy", 32'(busy), 32'h1);
    do_reset();
    check("t6_rst_p_out", 32'(p_out), 32'h0);
    check("t6_rst_valid", 32'(p_valid), 32'h0);
    check("t6_rst_ovf", 32'(overflow), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    p_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check("t6_p_out", 32'(p_out), 32'h9);
    check("t6_p_valid", 32'(p_valid), 32'h1);
    check("t6_overflow", 32'(overflow), 32'h0);

    // WIDTH=1: sync with a bit completes a word; every bit is a word
    w1_ready = 1'b0; w1_sync = 1'b1; w1_valid = 1'b1; w1_in = 1'b1;
    tick();
    w1_sync = 1'b0;
    check("w1_sync_p_out", 32'(w1_p_out), 32'h1);
    check("w1_sync_valid", 32'(w1_p_valid), 32'h1);
    check("w1_busy", 32'(w1_busy), 32'h0);
    w1_in = 1'b0;
    tick();
    check("w1_drop_p_out", 32'(w1_p_out), 32'h1);
    check("w1_overflow", 32'(w1_overflow), 32'h1);
    w1_ready = 1'b1;
    tick();
    w1_valid = 1'b0;
    check("w1_swap_p_out", 32'(w1_p_out), 32'h0);
    check("w1_swap_valid", 32'(w1_p_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Receive-side partner of the team's 4-bit parallel-in/serial-out shift register. Collects a serial bit stream into WIDTH-bit parallel words, MSB first by default, so a PISO output wired to serial_in reproduces the PISO's loaded word. Completed words are held in a one-entry output register with a valid/ready handshake. Words that arrive while that register is still occupied are dropped and flagged.

Parameters:
WIDTH, 4, word width in bits; legal for WIDTH >= 1.
MSB_FIRST, 1, 1 = first received bit is word bit WIDTH-1; 0 = first received bit is word bit 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
serial_in  input  1  serial data bit, sampled only when serial_valid=1.
serial_valid  input  1  qualifies serial_in for this cycle.
sync  input  1  start-of-word marker; discards any partial word.
p_out  output  WIDTH  completed parallel word.
p_valid  output  1  p_out holds an unconsumed word.
p_ready  input  1  consumer accepts p_out this cycle.
overflow  output  1  sticky flag: a completed word was dropped.
busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset (rst=1 at a clk edge): shift register = 0, bit count = 0, p_out = 0, p_valid = 0, overflow = 0, busy = 0. Reset overrides all other inputs, including a mid-word or mid-handshake state.
- Bit count runs from 0 to WIDTH-1. busy = (count != 0).
- Accepted bit: serial_valid=1 at an edge.
  - MSB_FIRST=1: shift register <= {shift register[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shift register <= {serial_in, shift register[WIDTH-1:1]}.
  - Count increments by 1.
- Word completion: the edge that accepts the WIDTH-th bit.
  - The assembled word, including that bit, is the candidate for p_out.
  - Count wraps to 0.
  - No extra latency: p_valid=1 is visible immediately after that edge.
- Output handshake: a transfer occurs at an edge where p_valid=1 and p_ready=1.
- Holding register update at a completion edge:
  - If p_valid=0, or p_valid=1 with p_ready=1: p_out <= new word, p_valid <= 1. Back-to-back words need no bubble.
  - If p_valid=1 and p_ready=0: new word discarded, p_out and p_valid unchanged, overflow <= 1.
- No completion and a transfer occurs: p_valid <= 0; p_out keeps its value.
- overflow clears only on rst.
- sync=1:
  - The partial word is discarded and count is cleared before considering serial_valid.
  - If serial_valid=1 in the same cycle, that bit is the first bit of the new word (count becomes 1).
  - With WIDTH=1, sync together with serial_valid completes a word.
  - sync does not affect p_out, p_valid or overflow.
- WIDTH=1: every accepted bit is a completed word.
- serial_valid=0 and sync=0: shift register and count hold; arbitrary gaps between bits are legal.
- p_ready while p_valid=0 has no effect.

Decomposition:
- Package sipo_pkg holds:
  - function cnt_w(WIDTH), giving $clog2(WIDTH) with a minimum of 1, used for the count width;
  - typedef enum bit_order_e {LSB_FIRST=0, MSB_FIRST=1}, shared with future PISO variants.
- No sub-module. Shift register, counter and holding register sit in one module, each as its own clocked process.

Test Plan:
1. WIDTH=4, MSB_FIRST=1: serial bits 1,0,1,1 on consecutive cycles with p_ready=1 -> after the 4th edge p_out=4'b1011 and p_valid=1 for one cycle; busy is 1 after bits 1-3 and 0 after bit 4.
2. Same word with serial_valid gaps of 0, 2 and 5 cycles between bits -> p_out=4'b1011; no change in p_out or p_valid during gaps. Repeat with MSB_FIRST=0 -> p_out=4'b1101.
3. Backpressure: p_ready=0; send 4'b1011, then 4'b0110 -> p_out stays 4'b1011, p_valid=1, overflow=1. Then p_ready=1 for one cycle -> p_valid=0 and overflow remains 1.
4. Simultaneous completion and drain: p_valid=1 with 4'b1011 held, p_ready=1 on the edge completing 4'b0101 -> p_out=4'b0101, p_valid stays 1, overflow=0.
5. sync: send bits 1,1, then sync=1 with serial_valid=1 and serial_in=0, then bits 1,1,0 -> p_out=4'b0110; the partial "11" never appears.
6. Reset mid-word and mid-handshake: 2 bits in, p_valid=1 pending, assert rst for one cycle -> all outputs 0. Then bits 1,0,0,1 -> p_out=4'b1001 with overflow=0.
